// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// access sizes and the alignment rule.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } access_size_e;

    // Map a funct3 code to its access size; unsupported codes fall back to byte
    // and are rejected separately by the funct3 validity check.
    function automatic access_size_e f3_size(logic [2:0] f3);
        access_size_e size;
        case (f3)
            F3_W:        size = SZ_W;
            F3_H, F3_HU: size = SZ_H;
            default:     size = SZ_B;
        endcase
        return size;
    endfunction

    // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
    function automatic logic is_aligned(access_size_e size, logic [1:0] lane);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lane[0];
            SZ_W:    ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus: request, sizing and load result.
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr,
        output rd,
        output addr,
        output funct3,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  wr,
        input  rd,
        input  addr,
        input  funct3,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Load extractor: picks the byte/halfword/word out of a stored word and
// sign- or zero-extends it according to funct3.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension.
    always_comb begin
        shifted  = word_i >> {lane_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            F3_W:    data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable little-endian storage with RV32I
// load/store sizing, a sticky fault register and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic                fault,
    output logic [ADDR_W-1:0]   fault_addr,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count
);

    localparam int unsigned Words = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem_q [Words];

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    access_size_e      size;
    logic              f3_ok;
    logic              legal;
    logic              illegal;
    logic              load_ok;
    logic              store_ok;
    logic [3:0]        byte_en;
    logic [31:0]       store_data;
    logic [31:0]       ext_data;

    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    assign word_idx = bus.addr[ADDR_W-1:2];
    assign lane     = bus.addr[1:0];

    // Legality decode from the current cycle's request.
    always_comb begin
        size = f3_size(bus.funct3);
        case (bus.funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = bus.rd; // unsigned forms exist only for loads
            default:          f3_ok = 1'b0;
        endcase
        legal    = (bus.wr ^ bus.rd) && f3_ok && is_aligned(size, lane);
        illegal  = (bus.wr | bus.rd) && !legal;
        load_ok  = bus.rd && legal;
        store_ok = bus.wr && legal;
    end

    // Store lane mask and data replicated across the lanes it may land in.
    always_comb begin
        byte_en    = 4'b0000;
        store_data = bus.wr_data;
        case (size)
            SZ_B: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{bus.wr_data[7:0]}};
            end
            SZ_H: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.wr_data[15:0]}};
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                store_data = bus.wr_data;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = bus.wr_data;
            end
        endcase
    end

    dmem_load_ext u_load_ext (
        .word_i   (mem_q[word_idx]),
        .lane_i   (lane),
        .funct3_i (bus.funct3),
        .data_o   (ext_data)
    );

    // Zero-latency load result, forced to zero unless a legal load is in progress.
    always_comb begin
        bus.rd_data = '0;
        if (load_ok && !reset) begin
            bus.rd_data = ext_data;
        end
    end

    // Storage: cleared on reset, otherwise byte-masked write on a legal store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
        end else if (store_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // Next-state for sticky fault capture and saturating counters.
    always_comb begin
        fault_d      = fault_q | illegal;
        fault_addr_d = fault_addr_q;
        if (illegal && !fault_q) begin
            fault_addr_d = bus.addr;
        end
        rd_count_d = rd_count_q;
        if (load_ok && (rd_count_q != {CNT_W{1'b1}})) begin
            rd_count_d = rd_count_q + 1'b1;
        end
        wr_count_d = wr_count_q;
        if (store_ok && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    // Fault and counter registers; reset overrides any same-cycle access.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with 4-bit counters so saturation is reachable.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fault;
    logic [AW-1:0] fault_addr;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    int total = 0;
    int bad   = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [31:0] rv;

    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_responder #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fault      (fault),
        .fault_addr (fault_addr),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // One bus cycle: drive after the falling edge, sample rd_data before the rising
    // edge, return just after it. Expected counters follow the saturating rule.
    task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [2:0] f, input logic [31:0] d, input logic legal,
                          output logic [31:0] rdv);
        @(negedge clk);
        bus.wr      = w;
        bus.rd      = r;
        bus.addr    = a;
        bus.funct3  = f;
        bus.wr_data = d;
        #1;
        rdv = bus.rd_data;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        if (legal && !reset) begin
            if (r && exp_rd < 15) exp_rd++;
            if (w && exp_wr < 15) exp_wr++;
        end
    endtask

    task automatic test_reset();
        bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.funct3 = F3_W; bus.wr_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
        total++; if (fault_addr !== 9'h000) begin bad++; $display("FAIL rst_faddr got=%h exp=000", fault_addr); end
        total++; if (rd_count !== 4'h0) begin bad++; $display("FAIL rst_rdcnt got=%h exp=0", rd_count); end
        total++; if (wr_count !== 4'h0) begin bad++; $display("FAIL rst_wrcnt got=%h exp=0", wr_count); end
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        access(1'b0, 1'b1, 9'h010, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL lw_010 got=%h exp=00000000", rv); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL t1_fault got=%b exp=0", fault); end
        total++; if (rd_count !== 4'h1) begin bad++; $display("FAIL t1_rdcnt got=%h exp=1", rd_count); end
    endtask

    task automatic test_word_store();
        access(1'b1, 1'b0, 9'h020, F3_W, 32'h12345678, 1'b1, rv);
        access(1'b0, 1'b1, 9'h020, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h12345678) begin bad++; $display("FAIL lw_020 got=%h exp=12345678", rv); end
        access(1'b0, 1'b1, 9'h023, F3_B, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00000012) begin bad++; $display("FAIL lb_023 got=%h exp=00000012", rv); end
        access(1'b0, 1'b1, 9'h021, F3_BU, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00000056) begin bad++; $display("FAIL lbu_021 got=%h exp=00000056", rv); end
        access(1'b0, 1'b1, 9'h022, F3_H, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00001234) begin bad++; $display("FAIL lh_022 got=%h exp=00001234", rv); end
        access(1'b0, 1'b1, 9'h020, F3_HU, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00005678) begin bad++; $display("FAIL lhu_020 got=%h exp=00005678", rv); end
        total++; if (wr_count !== 4'h1) begin bad++; $display("FAIL t2_wrcnt got=%h exp=1", wr_count); end
        total++; if (rd_count !== 4'(exp_rd)) begin bad++; $display("FAIL t2_rdcnt got=%h exp=%h", rd_count, 4'(exp_rd)); end
    endtask

    task automatic test_subword_store();
        access(1'b1, 1'b0, 9'h041, F3_B, 32'hAAAAAA80, 1'b1, rv);
        access(1'b0, 1'b1, 9'h040, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00008000) begin bad++; $display("FAIL sb_lw_040 got=%h exp=00008000", rv); end
        access(1'b0, 1'b1, 9'h041, F3_B, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_041 got=%h exp=ffffff80", rv); end
        access(1'b0, 1'b1, 9'h041, F3_BU, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h00000080) begin bad++; $display("FAIL lbu_041 got=%h exp=00000080", rv); end
        access(1'b1, 1'b0, 9'h042, F3_H, 32'h0000BEEF, 1'b1, rv);
        access(1'b0, 1'b1, 9'h040, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'hBEEF8000) begin bad++; $display("FAIL sh_lw_040 got=%h exp=beef8000", rv); end
    endtask

    task automatic test_top_address();
        access(1'b1, 1'b0, 9'h1FF, F3_B, 32'h123456F0, 1'b1, rv);
        access(1'b0, 1'b1, 9'h1FF, F3_B, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'hFFFFFFF0) begin bad++; $display("FAIL lb_1ff got=%h exp=fffffff0", rv); end
        access(1'b0, 1'b1, 9'h1FF, F3_BU, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h000000F0) begin bad++; $display("FAIL lbu_1ff got=%h exp=000000f0", rv); end
        access(1'b0, 1'b1, 9'h1FC, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'hF0000000) begin bad++; $display("FAIL lw_1fc got=%h exp=f0000000", rv); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL top_fault got=%b exp=0", fault); end
    endtask

    task automatic test_misaligned();
        access(1'b1, 1'b0, 9'h022, F3_W, 32'hDEADBEEF, 1'b0, rv);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%b exp=1", fault); end
        total++; if (fault_addr !== 9'h022) begin bad++; $display("FAIL mis_faddr got=%h exp=022", fault_addr); end
        total++; if (wr_count !== 4'(exp_wr)) begin bad++; $display("FAIL mis_wrcnt got=%h exp=%h", wr_count, 4'(exp_wr)); end
        access(1'b0, 1'b1, 9'h020, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h12345678) begin bad++; $display("FAIL mis_lw_020 got=%h exp=12345678", rv); end
        access(1'b0, 1'b1, 9'h031, F3_H, 32'h0, 1'b0, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL lh_031_data got=%h exp=00000000", rv); end
        total++; if (fault_addr !== 9'h022) begin bad++; $display("FAIL lh_031_faddr got=%h exp=022", fault_addr); end
        access(1'b0, 1'b1, 9'h020, 3'b011, 32'h0, 1'b0, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL bad_f3_load got=%h exp=00000000", rv); end
        access(1'b1, 1'b0, 9'h040, F3_BU, 32'h11111111, 1'b0, rv);
        access(1'b0, 1'b1, 9'h040, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'hBEEF8000) begin bad++; $display("FAIL bad_f3_store got=%h exp=beef8000", rv); end
        total++; if (rd_count !== 4'(exp_rd)) begin bad++; $display("FAIL mis_rdcnt got=%h exp=%h", rd_count, 4'(exp_rd)); end
        total++; if (wr_count !== 4'(exp_wr)) begin bad++; $display("FAIL mis_wrcnt2 got=%h exp=%h", wr_count, 4'(exp_wr)); end
    endtask

    task automatic test_both_req();
        access(1'b1, 1'b1, 9'h050, F3_W, 32'h11111111, 1'b0, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL both_data got=%h exp=00000000", rv); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL both_fault got=%b exp=1", fault); end
        total++; if (rd_count !== 4'(exp_rd)) begin bad++; $display("FAIL both_rdcnt got=%h exp=%h", rd_count, 4'(exp_rd)); end
        total++; if (wr_count !== 4'(exp_wr)) begin bad++; $display("FAIL both_wrcnt got=%h exp=%h", wr_count, 4'(exp_wr)); end
        access(1'b0, 1'b1, 9'h050, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL both_lw_050 got=%h exp=00000000", rv); end
    endtask

    task automatic test_saturation_and_reset();
        for (int i = 0; i < 17; i++) begin
            access(1'b0, 1'b1, 9'h020, F3_W, 32'h0, 1'b1, rv);
        end
        total++; if (rd_count !== 4'hF) begin bad++; $display("FAIL rd_sat got=%h exp=f", rd_count); end
        total++; if (wr_count !== 4'(exp_wr)) begin bad++; $display("FAIL sat_wrcnt got=%h exp=%h", wr_count, 4'(exp_wr)); end
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 1'b1, 9'h020, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=00000000", rv); end
        access(1'b1, 1'b0, 9'h060, F3_W, 32'hCAFEF00D, 1'b1, rv);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst2_fault got=%b exp=0", fault); end
        total++; if (fault_addr !== 9'h000) begin bad++; $display("FAIL rst2_faddr got=%h exp=000", fault_addr); end
        total++; if (rd_count !== 4'h0) begin bad++; $display("FAIL rst2_rdcnt got=%h exp=0", rd_count); end
        total++; if (wr_count !== 4'h0) begin bad++; $display("FAIL rst2_wrcnt got=%h exp=0", wr_count); end
        access(1'b0, 1'b1, 9'h060, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst2_lw_060 got=%h exp=00000000", rv); end
        access(1'b0, 1'b1, 9'h020, F3_W, 32'h0, 1'b1, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst2_lw_020 got=%h exp=00000000", rv); end
        total++; if (rd_count !== 4'h2) begin bad++; $display("FAIL rst2_rdcnt2 got=%h exp=2", rd_count); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_subword_store();
        test_top_address();
        test_misaligned();
        test_both_req();
        test_saturation_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that serves the core's data-memory port: wr, rd, addr, wr_data and rd_data.
- Byte-addressable, little-endian storage.
- RV32I load/store sizing and sign extension selected by funct3.
- Detects misalignment and protocol violations, recording them in a sticky fault register.
- Keeps saturating access counters for debug and verification.

Parameters:
DATA_W, 32, data word width in bits (fixed at 32 for RV32I sizing)
ADDR_W, 9, byte-address width; capacity is 2^ADDR_W bytes, organised as 2^(ADDR_W-2) words
CNT_W, 16, width of each access counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr  input  1  store request this cycle
rd  input  1  load request this cycle
addr  input  ADDR_W  byte address
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
wr_data  input  DATA_W  store data; sub-word stores use the low bits
rd_data  output  DATA_W  load result, extended per funct3
fault  output  1  sticky access-fault flag
fault_addr  output  ADDR_W  address of the first fault since reset
rd_count  output  CNT_W  accepted loads, saturating
wr_count  output  CNT_W  accepted stores, saturating

Behaviour:
Clocking and reset:
- One clock domain; reset is synchronous and active-high.
- At a posedge with reset=1:
  - every storage word is cleared to 0;
  - fault, fault_addr, rd_count and wr_count are cleared to 0;
  - any pending store is discarded.
- While reset=1, rd_data=0.

Access decode (combinational, from the current cycle's inputs):
- word index = addr[ADDR_W-1:2]; byte lane = addr[1:0].
- Access is "legal" only when all of these hold:
  - exactly one of wr/rd is 1;
  - funct3 is valid for the direction: loads accept 000, 001, 010, 100, 101; stores accept 000, 001, 010;
  - alignment holds: H/HU require addr[0]=0; W requires addr[1:0]=00.
- Illegal access = (wr|rd)=1 and not legal.

Loads (zero-latency, combinational):
- rd_data is valid in the same cycle as rd, matching the single-cycle core.
- B: selected byte, sign-extended. BU: selected byte, zero-extended.
- H: halfword at addr[1], sign-extended. HU: same halfword, zero-extended.
- W: full word.
- rd_data=0 whenever rd=0 or the access is illegal.

Stores (one-cycle write):
- A legal store updates only its byte lanes at the posedge: SB one lane, SH lanes {addr[1],0} and {addr[1],1}, SW all four lanes.
- Data is visible to a load from the next cycle onward. No same-cycle forwarding is needed because rd and wr are mutually exclusive in legal traffic.
- Illegal stores leave storage unchanged.

Fault register:
- At a posedge with reset=0 and an illegal access, fault is set to 1.
- fault_addr captures addr only if fault was 0 before that edge; later faults do not overwrite it.
- fault clears only on reset.
- The wr=rd=1 case is illegal: no write, rd_data=0.

Counters:
- rd_count increments on each legal load; wr_count increments on each legal store.
- Both saturate at all-ones and never wrap.
- Illegal accesses never count.

Boundaries:
- The highest address (2^ADDR_W - 1) is legal for B/BU.
- There is no out-of-range case, because addr spans exactly the capacity.
- If reset=1 coincides with any access, reset wins: no write, no count, no fault.

Decomposition:
- Package dmem_pkg holds:
  - localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - an enum access_size_e {SZ_B, SZ_H, SZ_W};
  - a function is_aligned(size, addr[1:0]).
- One combinational sub-module, dmem_load_ext: takes the raw word, byte lane and funct3, and returns the extended rd_data.
- Storage, store lane-masking, fault logic and counters stay in dmem_responder.

Test Plan:
1. Reset, then LW at 0x010 -> rd_data=0x00000000, fault=0, rd_count=1.
2. SW 0x12345678 at 0x020; next cycles:
   - LW 0x020 -> 0x12345678
   - LB 0x023 -> 0x00000012
   - LBU 0x021 -> 0x00000056
   - LH 0x022 -> 0x00001234
   - LHU 0x020 -> 0x00005678
3. SB wr_data=0xAAAAAA80 at 0x041 over a zeroed word:
   - LW 0x040 -> 0x00008000
   - LB 0x041 -> 0xFFFFFF80
   - LBU 0x041 -> 0x00000080
   - SH 0xBEEF at 0x042, then LW 0x040 -> 0xBEEF8000
4. SW 0xDEADBEEF at 0x022 (misaligned):
   - LW 0x020 still returns its old value;
   - fault=1 after the edge, fault_addr=0x022;
   - a later LH at 0x031 keeps fault_addr=0x022;
   - wr_count is unchanged.
5. wr=rd=1 at 0x050 with SW data 0x11111111 -> rd_data=0 that cycle, no write (LW 0x050 -> 0), fault set, counters unchanged.
6. Counter saturation and mid-operation reset:
   - With CNT_W=4, perform 17 legal loads -> rd_count=0xF.
   - Assert reset together with a legal SW -> storage and counters read 0 afterward, and fault=0.
